rst_seq_ctrl: RTL and testbench

Reset sequencer that sits directly upstream of the rst_n_piple delay stages. It synchronises PLL lock and DDR-init status, then releases three active-low domain resets in a fixed order: DDR controller, frame buffer, video pipeline. Each output feeds a rst_n_piple instance in its consumer region. Loss of lock or a software request re-asserts all resets and restarts the sequence.

---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/cdc_sync_bit.sv | 23 ++
 rtl/rst_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing for the domain reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_DDR_INIT  = 3'd1,
    S_GAP_FB    = 3'd2,
    S_GAP_VID   = 3'd3,
    S_RUN       = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_STAGE_GAP_CYC    = 16;
  localparam int unsigned DEF_INIT_TIMEOUT_CYC = 1048576;
  localparam int unsigned DEF_SYNC_STAGES      = 2;
  localparam int unsigned DEF_CNT_W            = 21;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input; clears to 0 on reset.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases DDR, frame-buffer and video resets in order once PLL lock is stable.
//   state       | meaning
//   S_WAIT_LOCK | all resets held, counting consecutive lock cycles
//   S_DDR_INIT  | DDR released, waiting for calibration or timeout
//   S_GAP_FB    | spacing before frame-buffer release
//   S_GAP_VID   | frame buffer released, spacing before video release
//   S_RUN       | all domains running
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned STAGE_GAP_CYC    = DEF_STAGE_GAP_CYC,
  parameter int unsigned INIT_TIMEOUT_CYC = DEF_INIT_TIMEOUT_CYC,
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       ddr_init_done_i,
  input  logic       sw_rst_i,
  output logic       ddr_rst_n_o,
  output logic       fb_rst_n_o,
  output logic       vid_rst_n_o,
  output logic [2:0] seq_state_o,
  output logic       timeout_o
);

  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_TC  = CNT_W'(INIT_TIMEOUT_CYC - 1);

  logic lock_s;
  logic done_s;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk   (clk),
    .rst_i (rst_i),
    .d_i   (ddr_init_done_i),
    .q_o   (done_s)
  );

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             ddr_q, ddr_d;
  logic             fb_q, fb_d;
  logic             vid_q, vid_d;
  logic             abort;

  assign abort = (state_q != S_WAIT_LOCK) && (!lock_s || sw_rst_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (sw_rst_i) begin
      timeout_d = 1'b0;
    end
    if (abort) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lock_s || sw_rst_i) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_TC) begin
            state_d = S_DDR_INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DDR_INIT: begin
          // Calibration finishing on the timeout cycle still counts as success.
          if (done_s) begin
            state_d = S_GAP_FB;
            cnt_d   = '0;
          end else if (cnt_q == TMO_TC) begin
            state_d   = S_WAIT_LOCK;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP_FB: begin
          if (cnt_q == GAP_TC) begin
            state_d = S_GAP_VID;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP_VID: begin
          if (cnt_q == GAP_TC) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they change on the transition edge.
  always_comb begin
    ddr_d = (state_d != S_WAIT_LOCK);
    fb_d  = (state_d == S_GAP_VID) || (state_d == S_RUN);
    vid_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_WAIT_LOCK;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ddr_q     <= 1'b0;
      fb_q      <= 1'b0;
      vid_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ddr_q     <= ddr_d;
      fb_q      <= fb_d;
      vid_q     <= vid_d;
    end
  end

  assign ddr_rst_n_o = ddr_q;
  assign fb_rst_n_o  = fb_q;
  assign vid_rst_n_o = vid_q;
  assign seq_state_o = state_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: phase-level reference model vs. registered outputs.
module tb_rst_seq_ctrl;

  localparam int LOCK = 8;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       ddr_init_done_i = 1'b0;
  logic       sw_rst_i = 1'b0;
  logic       ddr_rst_n_o, fb_rst_n_o, vid_rst_n_o, timeout_o;
  logic [2:0] seq_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  rst_seq_ctrl #(
    .LOCK_STABLE_CYC  (LOCK),
    .STAGE_GAP_CYC    (GAP),
    .INIT_TIMEOUT_CYC (TMO),
    .SYNC_STAGES      (SYNC),
    .CNT_W            (21)
  ) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .pll_locked_i    (pll_locked_i),
    .ddr_init_done_i (ddr_init_done_i),
    .sw_rst_i        (sw_rst_i),
    .ddr_rst_n_o     (ddr_rst_n_o),
    .fb_rst_n_o      (fb_rst_n_o),
    .vid_rst_n_o     (vid_rst_n_o),
    .seq_state_o     (seq_state_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0..4 with a count of cycles spent in the phase.
  logic [6:0] exp_q[$];
  bit         m_lk[SYNC];
  bit         m_dn[SYNC];
  int         m_phase;
  int         m_elapsed;
  bit         m_tmo;

  function automatic logic [6:0] pack_exp(int ph, bit tmo);
    logic [2:0] st;
    st = 3'(ph);
    return {ph >= 1, ph >= 3, ph == 4, st, tmo};
  endfunction

  always @(posedge clk or posedge rst_i) begin
    bit ls, ds;
    if (rst_i) begin
      for (int i = 0; i < SYNC; i++) begin
        m_lk[i] = 1'b0;
        m_dn[i] = 1'b0;
      end
      m_phase   = 0;
      m_elapsed = 0;
      m_tmo     = 1'b0;
      exp_q.delete();
      exp_q.push_back(pack_exp(0, 1'b0));
    end else begin
      ls = m_lk[SYNC-1];
      ds = m_dn[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) begin
        m_lk[i] = m_lk[i-1];
        m_dn[i] = m_dn[i-1];
      end
      m_lk[0] = pll_locked_i;
      m_dn[0] = ddr_init_done_i;
      if (sw_rst_i) m_tmo = 1'b0;
      if (m_phase != 0 && (!ls || sw_rst_i)) begin
        m_phase   = 0;
        m_elapsed = 0;
      end else if (m_phase == 0) begin
        if (ls && !sw_rst_i) m_elapsed++;
        else m_elapsed = 0;
        if (m_elapsed == LOCK) begin
          m_phase   = 1;
          m_elapsed = 0;
        end
      end else if (m_phase == 1) begin
        m_elapsed++;
        if (ds) begin
          m_phase   = 2;
          m_elapsed = 0;
        end else if (m_elapsed == TMO) begin
          m_phase   = 0;
          m_elapsed = 0;
          m_tmo     = 1'b1;
        end
      end else if (m_phase == 2 || m_phase == 3) begin
        m_elapsed++;
        if (m_elapsed == GAP) begin
          m_phase   = m_phase + 1;
          m_elapsed = 0;
        end
      end
      exp_q.push_back(pack_exp(m_phase, m_tmo));
    end
  end

  always @(negedge clk) begin
    logic [6:0] got, want;
    got = {ddr_rst_n_o, fb_rst_n_o, vid_rst_n_o, seq_state_o, timeout_o};
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: {ddr,fb,vid,state,tmo} got %b_%b_%b_%0d_%b want %b_%b_%b_%0d_%b",
                 $time, got[6], got[5], got[4], got[3:1], got[0],
                 want[6], want[5], want[4], want[3:1], want[0]);
      end
    end
    n_tests++;
    if ((vid_rst_n_o && !fb_rst_n_o) || (fb_rst_n_o && !ddr_rst_n_o)) begin
      n_fail++;
      $display("FAIL ordering @%0t: ddr=%b fb=%b vid=%b, required monotone release",
               $time, ddr_rst_n_o, fb_rst_n_o, vid_rst_n_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sw();
    sw_rst_i = 1'b1;
    @(negedge clk);
    sw_rst_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k;
    k = 0;
    while (seq_state_o !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (seq_state_o !== s) begin
      n_fail++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", tag, seq_state_o, s, budget);
    end
  endtask

  task automatic check_bit(input logic got, input logic want, input string tag);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", tag, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal sequence with lock stable from reset release.
    pll_locked_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    wait_state(3'd1, 40, "s1_ddr_release");
    tick(20);
    ddr_init_done_i = 1'b1;
    wait_state(3'd4, 40, "s1_run");

    // Lock loss in run; drop length randomised.
    tick(3);
    pll_locked_i = 1'b0;
    tick($urandom_range(1, 3));
    pll_locked_i = 1'b1;
    wait_state(3'd4, 60, "s4_rerun");

    // Software reset while frame buffer is released and video is still held.
    pulse_sw();
    wait_state(3'd3, 60, "s5_gap_vid");
    tick($urandom_range(0, 2));
    pulse_sw();
    check_bit(fb_rst_n_o, 1'b0, "s5_fb_after_sw");
    wait_state(3'd4, 60, "s5_rerun");

    // Single-cycle lock glitch after a few stable cycles in wait-lock.
    pulse_sw();
    pll_locked_i = 1'b0;
    tick(3);
    pll_locked_i = 1'b1;
    tick(5);
    pll_locked_i = 1'b0;
    tick(1);
    pll_locked_i = 1'b1;
    wait_state(3'd4, 60, "s2_recover");

    // DDR init timeout, retry, then clear via software reset.
    ddr_init_done_i = 1'b0;
    pulse_sw();
    wait_state(3'd1, 40, "s3_enter_init");
    wait_state(3'd0, TMO + 8, "s3_timeout");
    check_bit(timeout_o, 1'b1, "s3_timeout_flag");
    check_bit(ddr_rst_n_o, 1'b0, "s3_ddr_reasserted");
    wait_state(3'd1, 40, "s3_retry_init");
    wait_state(3'd0, TMO + 8, "s3_timeout_again");
    check_bit(timeout_o, 1'b1, "s3_flag_sticky");
    tick(2);
    pulse_sw();
    check_bit(timeout_o, 1'b0, "s3_flag_cleared");
    ddr_init_done_i = 1'b1;
    wait_state(3'd4, 60, "s3_run");

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_bit(ddr_rst_n_o, 1'b0, "s6_async_ddr");
    check_bit(fb_rst_n_o, 1'b0, "s6_async_fb");
    check_bit(vid_rst_n_o, 1'b0, "s6_async_vid");
    check_bit(timeout_o, 1'b0, "s6_async_tmo");
    tick(3);
    rst_i = 1'b0;
    wait_state(3'd4, 60, "s6_rerun");

    // Random soak against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sw_rst_i = ($urandom_range(0, 199) == 0);
      if (pll_locked_i) begin
        if ($urandom_range(0, 79) == 0) pll_locked_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        pll_locked_i = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) ddr_init_done_i = ~ddr_init_done_i;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_i = 1'b1;
        @(negedge clk);
        #2 rst_i = 1'b0;
      end
    end
    sw_rst_i = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
